fp16_unpack: RTL and testbench
==============================

FP16_UNPACK -- requirements
Module: fp16_unpack

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  one-cycle strobe: sign/exp/mant are valid (driven by the field-capture stage's valid pulse).
REQ-004 sign  input  1  FP16 sign field.
REQ-005 exp  input  5  FP16 biased exponent field.
REQ-006 mant  input  10  FP16 mantissa field.
REQ-007 busy  output  1  high while state is not IDLE.
REQ-008 out_valid  output  1  one-cycle pulse: result outputs updated.
REQ-009 out_sign  output  1  sign of result.
REQ-010 out_exp  output  7  unbiased exponent, two's complement.
REQ-011 out_sig  output  11  significand with explicit leading bit at [10].
REQ-012 out_cls  output  3  class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.
REQ-013 drop  output  1  one-cycle pulse: in_valid seen while busy, input discarded.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; in_valid SHALL be accepted only in IDLE.
REQ-015 Accept at edge k: fields captured; classify; next state SHIFT if subnormal (exp=0, mant!=0), else DONE.
REQ-016 Zero (exp=0, mant=0): out_exp=0, out_sig=0, out_cls=0, sign preserved.
REQ-017 Normal (exp 1..30): out_exp=exp-15 (range -14..15), out_sig={1,mant}, out_cls=2.
REQ-018 Inf (exp=31, mant=0): out_exp=16, out_sig=0x400, out_cls=3.
REQ-019 NaN (exp=31, mant!=0): out_exp=16, out_sig={1,mant}, out_cls=4 if mant[9]=1 else 5.
REQ-020 Subnormal: working sig={0,mant}, working exp=-14; each SHIFT edge sig<<=1, exp-=1; leave SHIFT for DONE at the edge where the shifted sig[10]=1; out_cls=1.
REQ-021 Shift count SHALL be 10-p, p = index of leading one of mant; mant=1 gives out_exp=-24.
REQ-022 DONE edge SHALL load all out_* registers, pulse out_valid, return to IDLE.
REQ-023 Latency: non-subnormal out_valid high after edge k+1; subnormal after edge k+1+(10-p); max k+11.
REQ-024 busy SHALL be low in the out_valid cycle; a new in_valid there is accepted (throughput one result per 2 cycles for non-subnormals).
REQ-025 in_valid while busy SHALL be ignored, pulse drop for that cycle, and not disturb the in-flight result.
REQ-026 out_sign/out_exp/out_sig/out_cls SHALL hold between out_valid pulses.

Reset
REQ-027 rst at an edge SHALL force IDLE and clear busy, out_valid, drop, out_sign, out_exp, out_sig, out_cls to 0.
REQ-028 rst SHALL dominate in_valid in the same cycle; input is not accepted.
REQ-029 rst during SHIFT or DONE SHALL abort the operation with no out_valid.

Configuration
REQ-030 Macro FP16_UNPACK_FTZ_EN: defined -> subnormals flushed: out_cls=0, out_exp=0, out_sig=0, sign kept, latency as non-subnormal, SHIFT unreachable.
REQ-031 Undefined -> subnormals normalized per REQ-020..023.

Verification
REQ-032 0x3C00 (sign0, exp15, mant0) -> out_valid after edge k+1, out_exp=0, out_sig=0x400, out_cls=2.
REQ-033 0x0001 -> out_valid after edge k+11, out_exp=-24 (0x68), out_sig=0x400, out_cls=1; with FTZ: k+1, cls=0, sig=0.
REQ-034 0x0200 -> one shift, out_exp=-15, out_sig=0x400, out_cls=1; 0x8000 -> cls=0, out_sign=1.
REQ-035 0x7E00 -> cls=4, out_exp=16, out_sig=0x600; 0x7C01 -> cls=5, out_sig=0x401; 0xFC00 -> cls=3, out_sign=1.
REQ-036 0x0001 accepted, in_valid pulse 3 cycles later -> drop=1 one cycle, result still exp=-24, no second out_valid.
REQ-037 0x0001 accepted, rst at 4th SHIFT edge -> busy=0, all outputs 0, no out_valid; next 0x3C00 handled normally.

Source files
------------

// File: rtl/fp16_unpack.sv
// fp16_unpack: classify an FP16 value and normalize it into sign, unbiased exponent and explicit-one significand (FP16_UNPACK_FTZ_EN flushes subnormals to zero)
module fp16_unpack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        sign,
    input  logic [4:0]  exp,
    input  logic [9:0]  mant,
    output logic        busy,
    output logic        out_valid,
    output logic        out_sign,
    output logic [6:0]  out_exp,
    output logic [10:0] out_sig,
    output logic [2:0]  out_cls,
    output logic        drop
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic        w_sign;
    logic [6:0]  w_exp, c_exp;
    logic [10:0] w_sig, c_sig;
    logic [2:0]  w_cls, c_cls;
    logic        sub;
    assign busy = state != IDLE;
    // classify the incoming fields into the working-register start values
    always_comb begin
        sub = 1'b0;
        c_exp = 7'd0;
        c_sig = 11'd0;
        c_cls = 3'd0;
        if (exp == 5'd0 && mant != 10'd0) begin
`ifdef FP16_UNPACK_FTZ_EN
            c_cls = 3'd0;
`else
            sub = 1'b1;
            c_exp = 7'h72;
            c_sig = {1'b0, mant};
            c_cls = 3'd1;
`endif
        end else if (exp == 5'd31) begin
            c_exp = 7'd16;
            c_sig = {1'b1, mant};
            c_cls = mant == 10'd0 ? 3'd3 : mant[9] ? 3'd4 : 3'd5;
        end else if (exp != 5'd0) begin
            c_exp = {2'b00, exp} - 7'd15;
            c_sig = {1'b1, mant};
            c_cls = 3'd2;
        end
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state: subnormals walk through SHIFT until the shifted leading one reaches bit 10
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = sub ? SHIFT : DONE;
            SHIFT:   if (w_sig[9]) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // working registers, result registers, and the valid/drop strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            w_sign    <= 1'b0;
            w_exp     <= 7'd0;
            w_sig     <= 11'd0;
            w_cls     <= 3'd0;
            out_valid <= 1'b0;
            drop      <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= 7'd0;
            out_sig   <= 11'd0;
            out_cls   <= 3'd0;
        end else begin
            out_valid <= state == DONE;
            drop      <= in_valid && busy;
            if (in_valid && state == IDLE) begin
                w_sign <= sign;
                w_exp  <= c_exp;
                w_sig  <= c_sig;
                w_cls  <= c_cls;
            end else if (state == SHIFT) begin
                w_sig <= w_sig << 1;
                w_exp <= w_exp - 7'd1;
            end
            if (state == DONE) begin
                out_sign <= w_sign;
                out_exp  <= w_exp;
                out_sig  <= w_sig;
                out_cls  <= w_cls;
            end
        end
    end
endmodule

// File: tb/tb_fp16_unpack.sv
// tb_fp16_unpack: randomized scoreboard bench for fp16_unpack against an arithmetic reference model
module tb_fp16_unpack;
    logic        clk = 1'b0;
    logic        rst, in_valid, sign;
    logic [4:0]  fexp;
    logic [9:0]  mant;
    logic        busy, out_valid, out_sign, drop;
    logic [6:0]  out_exp;
    logic [10:0] out_sig;
    logic [2:0]  out_cls;

    fp16_unpack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sign(sign), .exp(fexp), .mant(mant),
        .busy(busy), .out_valid(out_valid), .out_sign(out_sign), .out_exp(out_exp),
        .out_sig(out_sig), .out_cls(out_cls), .drop(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [6:0]  e;
        logic [10:0] g;
        logic [2:0]  c;
        int          t;
    } res_t;

    res_t sb[$];
    int   dq[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   b_lo = 0, b_hi = 0;
    bit   run = 0;
    res_t hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
        end
    endtask

    // reference: value = (-1)^s * 2^(e-15) * 1.m, or m * 2^-24 for subnormals
    function automatic res_t model(input logic s, input logic [4:0] e, input logic [9:0] m);
        res_t r;
        int p;
        r.s = s; r.e = 7'd0; r.g = 11'd0; r.c = 3'd0; r.t = 1;
        if (e == 0 && m != 0) begin
`ifndef FP16_UNPACK_FTZ_EN
            p = 9;
            while (!m[p]) p--;
            r.e = 7'(p - 24);
            r.g = 11'(m) << (10 - p);
            r.c = 3'd1;
            r.t = 11 - p;
`endif
        end else if (e == 31) begin
            r.e = 7'd16;
            r.g = 11'(1024 + int'(m));
            r.c = m == 0 ? 3'd3 : (m[9] ? 3'd4 : 3'd5);
        end else if (e != 0) begin
            r.e = 7'(int'(e) - 15);
            r.g = 11'(1024 + int'(m));
            r.c = 3'd2;
        end
        return r;
    endfunction

    // monitor: compares DUT against scheduled results, drop strobes and held outputs
    always @(negedge clk) begin
        if (run) begin
            res_t r;
            bit ev, ed;
            chk("busy", busy, cyc >= b_lo && cyc < b_hi);
            ev = sb.size() > 0 && sb[0].t == cyc;
            chk("out_valid", out_valid, ev);
            if (out_valid && sb.size() > 0) begin
                r = sb.pop_front();
                chk("latency", cyc, r.t);
                hold = r;
            end
            chk("out_sign", out_sign, hold.s);
            chk("out_exp", out_exp, hold.e);
            chk("out_sig", out_sig, hold.g);
            chk("out_cls", out_cls, hold.c);
            ed = dq.size() > 0 && dq[0] == cyc;
            chk("drop", drop, ed);
            if (ed) void'(dq.pop_front());
        end
    end

    // issue one value; pulse stray in_valid while busy: nz<0 random, nz>0 at that offset only
    task automatic send(input logic [15:0] v, input bit push, input int nz, input int stop);
        res_t r;
        int k, lat;
        r = model(v[15], v[14:10], v[9:0]);
        lat = r.t;
        @(negedge clk);
        in_valid = 1'b1;
        {sign, fexp, mant} = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = cyc;
        b_lo = k;
        b_hi = k + lat;
        if (push) begin
            r.t = k + lat;
            sb.push_back(r);
        end
        for (int j = 1; j <= lat && j <= stop; j++) begin
            @(negedge clk);
            in_valid = nz < 0 ? ($urandom_range(0, 3) == 0) : (nz == j);
            {sign, fexp, mant} = 16'($urandom);
            @(posedge clk); #1;
            if (in_valid) dq.push_back(cyc);
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input bit with_valid);
        @(negedge clk);
        rst = 1'b1;
        in_valid = with_valid;
        {sign, fexp, mant} = 16'h3C00;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        if (b_hi > cyc) b_hi = cyc;
        hold = '{1'b0, 7'd0, 11'd0, 3'd0, 0};
    endtask

    initial begin
        logic [15:0] v;
        rst = 1'b1; in_valid = 1'b0; sign = 1'b0; fexp = 5'd0; mant = 10'd0;
        hold = '{1'b0, 7'd0, 11'd0, 3'd0, 0};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1;
        send(16'h3C00, 1, 0, 99);
        send(16'h0001, 1, 0, 99);
        send(16'h0200, 1, 0, 99);
        send(16'h8000, 1, 0, 99);
        send(16'h7E00, 1, 0, 99);
        send(16'h7C01, 1, 0, 99);
        send(16'hFC00, 1, 0, 99);
        send(16'h0001, 1, 3, 99);
        send(16'h0001, 0, 0, 3);
        do_reset(1'b0);
        send(16'h3C00, 1, 0, 99);
        do_reset(1'b1);
        send(16'h3C00, 1, 0, 99);
        for (int i = 0; i < 300; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v[14:10] = 5'd0;
            else if ($urandom_range(0, 7) == 0) v[14:10] = 5'd31;
            send(v, 1, -1, 99);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        repeat (15) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        chk("drop_queue_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
